// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   uart_tx_state_e  - transmitter FSM state encoding
//   cycles_per_bit() - clock cycles per line bit for a given clock and baud
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  // clk_mhz in MHz, baud in bit/s; truncating division
  function automatic int cycles_per_bit(input int clk_mhz, input int baud);
    return (clk_mhz * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with first-word fall-through read data.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (pointers/count only)
//   i_push       write request; ignored when the FIFO holds DEPTH entries
//   i_wr_data    write data
//   i_pop        read request; ignored when empty
//   o_rd_data    head entry (valid while !o_empty)
//   o_full       registered, count == DEPTH
//   o_empty      count == 0
//   o_count      number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic [CW-1:0]    w_count_nxt;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Both qualifiers look only at the registered count, so a push at full
  // is dropped even when a pop frees a slot in the same cycle.
  assign w_push_ok = i_push && (r_count < CW'(DEPTH));
  assign w_pop_ok  = i_pop  && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      // pointers wrap naturally since DEPTH is a power of two
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered 8N1 UART transmitter, LSB first. Absorbs single-cycle byte strobes
// (no backpressure to the source) in a FIFO and sends frames back to back.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   tx_data         byte to send, sampled with tx_data_valid
//   tx_data_valid   single-cycle write strobe
//   tx_fifo_full    FIFO holds FIFO_DEPTH entries (registered)
//   tx_overflow     sticky: a write was dropped; cleared by reset only
//   tx_busy         FSM not IDLE or FIFO non-empty
//   tx_pin          serial line, idle high, driven from a flop
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 48,
  parameter int BAUD_RATE  = 3000000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_fifo_full,
  output logic       tx_overflow,
  output logic       tx_busy,
  output logic       tx_pin
);

  localparam int CPB = cycles_per_bit(CLK_FRE, BAUD_RATE);
  localparam int BW  = (CPB < 2) ? 1 : $clog2(CPB);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  if (CPB < 2) begin : g_chk_cpb
    $error("uart_tx_buffered: CLK_FRE/BAUD_RATE gives fewer than 2 cycles per bit");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two and >= 2");
  end

  uart_tx_state_e r_state, w_state_nxt;
  logic [BW-1:0]  r_baud,  w_baud_nxt;
  logic [2:0]     r_bit,   w_bit_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic           r_tx_pin, w_pin_nxt;
  logic           r_overflow;

  logic           w_pop;
  logic           w_bit_end;
  logic [7:0]     w_fifo_data;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [CW-1:0]  w_fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (tx_data_valid),
    .i_wr_data (tx_data),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx_pin <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_tx_pin <= w_pin_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          // pop on the last stop cycle so the next start bit follows with no gap
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so the pin flop lines up
  // with the state register cycle for cycle.
  always_comb begin
    w_pin_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_pin_nxt = 1'b0;
      DATA:    w_pin_nxt = w_shift_nxt[0];
      default: w_pin_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (tx_data_valid && w_fifo_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign tx_pin       = r_tx_pin;
  assign tx_fifo_full = w_fifo_full;
  assign tx_overflow  = r_overflow;
  assign tx_busy      = (r_state != IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx_fifo_full, tx_overflow, tx_busy, tx_pin;

  uart_tx_buffered #(
    .CLK_FRE    (48),
    .BAUD_RATE  (3000000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_fifo_full  (tx_fifo_full),
    .tx_overflow   (tx_overflow),
    .tx_busy       (tx_busy),
    .tx_pin        (tx_pin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;   // expected cycle of first start-bit cycle, -1 = don't care
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_busy = 1'b0;

  logic [7:0] tbl [18] = '{8'h3C, 8'hC3, 8'h55, 8'hAA, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12,
                           8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'h99};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tx_data_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || mon_busy || tx_busy) && k < budget) begin
      step();
      k++;
    end
    chk("drain_done", (k < budget), 1);
  endtask

  // Monitor: decodes frames from tx_pin (mid-bit sampling) and compares them
  // with the scoreboard queue.
  initial begin
    int         p;
    int         st;
    logic       prev;
    logic [7:0] sh;
    exp_t       e;
    p = 0; st = 0; prev = 1'b1; sh = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        mon_busy = 1'b0;
        prev = 1'b1;
      end else begin
        if (!mon_busy) begin
          if (tx_pin == 1'b0 && prev == 1'b1) begin
            mon_busy = 1'b1;
            p = 0;
            st = cyc;
          end
        end else begin
          p++;
        end
        if (mon_busy) begin
          if (p % CPB == CPB / 2) begin
            if (p / CPB == 0)      chk("start_bit", tx_pin, 0);
            else if (p / CPB == 9) chk("stop_bit", tx_pin, 1);
            else                   sh[p / CPB - 1] = tx_pin;
          end
          if (p == FRAME - 1) begin
            mon_busy = 1'b0;
            chk("frame_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              chk("frame_data", sh, e.data);
              if (e.start >= 0) chk("frame_start_cycle", st, e.start);
            end
          end
        end
        prev = tx_pin;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();

    // idle after reset
    for (int i = 0; i < 100; i++) begin
      chk("idle_pin", tx_pin, 1);
      chk("idle_busy", tx_busy, 0);
      chk("idle_full", tx_fifo_full, 0);
      chk("idle_ovf", tx_overflow, 0);
      step();
    end

    // single byte 0xA5 latency and frame
    n = cyc;
    tx_data = 8'hA5; tx_data_valid = 1'b1;
    sb.push_back('{8'hA5, n + 2});
    step();
    tx_data_valid = 1'b0;
    chk("a5_pin_n1", tx_pin, 1);
    step();
    chk("a5_pin_n2", tx_pin, 0);
    chk("a5_busy", tx_busy, 1);
    wait_to(n + 2 + CPB + 8);           // mid data bit 0 (LSB of A5 = 1)
    chk("a5_bit0", tx_pin, 1);
    wait_to(n + 2 + 2 * CPB + 8);       // data bit 1 = 0
    chk("a5_bit1", tx_pin, 0);
    wait_to(n + 1 + FRAME);
    chk("a5_busy_last_stop", tx_busy, 1);
    step();
    chk("a5_busy_after", tx_busy, 0);
    chk("a5_pin_after", tx_pin, 1);
    drain(400);

    // three back-to-back bytes
    n = cyc;
    tx_data = 8'h01; tx_data_valid = 1'b1; sb.push_back('{8'h01, n + 2});
    step();
    tx_data = 8'h80; sb.push_back('{8'h80, n + 2 + FRAME});
    step();
    tx_data = 8'hFF; sb.push_back('{8'hFF, n + 2 + 2 * FRAME});
    step();
    tx_data_valid = 1'b0;
    wait_to(n + 1 + 3 * FRAME);
    chk("burst3_busy_end", tx_busy, 1);
    step();
    chk("burst3_idle", tx_busy, 0);
    drain(400);

    // 18 consecutive writes: byte 17 dropped
    do_reset();
    n = cyc;
    for (int i = 0; i < 18; i++) begin
      tx_data = tbl[i]; tx_data_valid = 1'b1;
      if (i < 17) sb.push_back('{tbl[i], n + 2 + i * FRAME});
      chk("ovf_full_during", tx_fifo_full, (i == 17) ? 1 : 0);
      chk("ovf_flag_during", tx_overflow, 0);
      step();
    end
    tx_data_valid = 1'b0;
    chk("ovf_set", tx_overflow, 1);
    chk("ovf_full_after", tx_fifo_full, 1);
    drain(4000);
    chk("ovf_sticky", tx_overflow, 1);

    // write at full in the same cycle as the STOP-end pop
    do_reset();
    n = cyc;
    for (int i = 0; i < 17; i++) begin
      tx_data = tbl[i]; tx_data_valid = 1'b1;
      sb.push_back('{tbl[i], n + 2 + i * FRAME});
      step();
    end
    tx_data_valid = 1'b0;
    chk("hold_full", tx_fifo_full, 1);
    chk("hold_ovf0", tx_overflow, 0);
    wait_to(n + 1 + FRAME);             // last stop cycle of frame 0: pop happens here
    chk("hold_full_pre_pop", tx_fifo_full, 1);
    tx_data = 8'hEE; tx_data_valid = 1'b1;
    step();
    tx_data_valid = 1'b0;
    chk("pop_full_count15", tx_fifo_full, 0);
    chk("pop_full_ovf", tx_overflow, 1);
    drain(4000);

    // reset during data bit 3 of the first frame with 4 bytes queued
    do_reset();
    n = cyc;
    for (int i = 0; i < 4; i++) begin
      tx_data = tbl[i + 4]; tx_data_valid = 1'b1;
      step();
    end
    tx_data_valid = 1'b0;
    wait_to(n + 2 + 4 * CPB + 4);
    chk("abort_busy_before", tx_busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_pin", tx_pin, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_full", tx_fifo_full, 0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      chk("abort_quiet_pin", tx_pin, 1);
    end
    chk("abort_quiet_busy", tx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
